// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and the buffered ALU result entry type for the writeback arbiter.
package wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int ENTRY_W = REG_AW + XLEN;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO for ALU writeback results.
//   clk, rst    : clock, asynchronous active-high reset (empties the FIFO)
//   push, din   : write request and entry; ignored while full
//   pop         : read request; ignored while empty
//   full, empty : occupancy flags from registered pointers only
//   dout        : current head entry
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging a buffered ALU stream and an unbuffered LSU stream
// onto the single register-file write port. LSU has priority; a starvation counter forces
// an ALU win after MAX_STALL consecutive losses.
//   clk, rst                        : clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake into the FIFO
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : load result handshake, granted directly
//   reg_write/rd_addr/rd_data       : registered register-file write port
//   idle                            : FIFO empty and no write in flight
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ALU_DEPTH = 4,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              reg_write,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data,
  output logic              idle
);
  localparam int SW = $clog2(MAX_STALL + 1);
  wb_entry_t head;
  logic fifo_full, fifo_empty, force_alu, lsu_win, alu_pop, win_present;
  logic [REG_AW-1:0] win_rd;
  logic [XLEN-1:0] win_data;
  logic [SW-1:0] starve_cnt;
  wb_fifo #(.DEPTH(ALU_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_valid),
    .pop   (alu_pop),
    .din   ({alu_rd, alu_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head)
  );
  assign alu_ready = !fifo_full;
  assign force_alu = !fifo_empty && starve_cnt == SW'(MAX_STALL);
  assign lsu_ready = !force_alu;
  assign lsu_win = lsu_valid && !force_alu;
  assign alu_pop = !fifo_empty && !lsu_win;
  assign win_present = lsu_win || alu_pop;
  assign win_rd = lsu_win ? lsu_rd : head.rd;
  assign win_data = lsu_win ? lsu_data : head.data;
  assign idle = fifo_empty && !reg_write;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      starve_cnt <= '0;
      reg_write <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      // With a nonempty FIFO and no ALU pop, the LSU necessarily won this cycle.
      starve_cnt <= (fifo_empty || alu_pop) ? '0 :
                    (starve_cnt == SW'(MAX_STALL)) ? starve_cnt : starve_cnt + SW'(1);
      reg_write <= win_present && win_rd != '0;
      if (win_present && win_rd != '0) begin
        rd_addr <= win_rd;
        rd_data <= win_data;
      end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and scoreboarded checks of the writeback arbiter.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, reg_write, idle;
  logic [4:0] alu_rd, lsu_rd, rd_addr;
  logic [31:0] alu_data, lsu_data, rd_data;
  int checks = 0;
  int errors = 0;
  int id, stall, qn;
  logic is_alu, acc_l, acc_a;
  logic [4:0] l_rd, a_rd;
  logic [31:0] l_data, a_data;
  logic [4:0] q_rd[$];
  logic [31:0] q_data[$];

  wb_arbiter #(.ALU_DEPTH(4), .MAX_STALL(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .reg_write (reg_write),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    #1;
    chk("rst_we", reg_write, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_idle", idle, 1);
    step();
    rst = 1'b0;
    step();

    // Reset mid-traffic with three ALU results buffered behind a busy LSU.
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    alu_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_rd = 5'(i); alu_data = 32'h500 + i;
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("t1_pre_we", reg_write, 1);
    chk("t1_pre_idle", idle, 0);
    #2 rst = 1'b1;
    #1;
    chk("t1_we", reg_write, 0);
    chk("t1_alu_ready", alu_ready, 1);
    chk("t1_idle", idle, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_stale_we", reg_write, 0);
      chk("t1_stale_idle", idle, 1);
    end

    // Single ALU push: written two cycles after acceptance.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk("t2_n1_we", reg_write, 0);
    chk("t2_n1_idle", idle, 0);
    step();
    chk("t2_we", reg_write, 1);
    chk("t2_addr", rd_addr, 5);
    chk("t2_data", rd_data, 32'hDEADBEEF);
    step();
    chk("t2_after_we", reg_write, 0);
    chk("t2_after_idle", idle, 1);

    // LSU rd=0 completes the handshake without a write; outputs hold.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    chk("t4_lsu_ready", lsu_ready, 1);
    step();
    chk("t4_we", reg_write, 0);
    chk("t4_hold_addr", rd_addr, 5);
    chk("t4_hold_data", rd_data, 32'hDEADBEEF);
    lsu_rd = 5'd7; lsu_data = 32'hAA;
    step();
    lsu_valid = 1'b0;
    chk("t4_lsu_we", reg_write, 1);
    chk("t4_lsu_addr", rd_addr, 7);
    chk("t4_lsu_data", rd_data, 32'hAA);
    step();

    // Five ALU pushes under continuous LSU traffic: fill, refused push on full+pop,
    // 3 LSU wins then a forced ALU win, ALU order 1..5 across the pointer wrap.
    for (int e = 0; e <= 20; e++) begin
      alu_valid = e <= 5;
      id = e < 4 ? e + 1 : 5;
      alu_rd = 5'(id); alu_data = 32'h100 + id;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h2000 + e;
      step();
      is_alu = e > 0 && e % 4 == 0;
      chk($sformatf("t3_we_%0d", e), reg_write, 1);
      chk($sformatf("t3_addr_%0d", e), rd_addr, is_alu ? e / 4 : 20);
      chk($sformatf("t3_data_%0d", e), rd_data, is_alu ? 32'h100 + e / 4 : 32'h2000 + e);
      chk($sformatf("t3_alu_ready_%0d", e), alu_ready, (e < 3 || e == 4 || e >= 8) ? 1 : 0);
      chk($sformatf("t3_lsu_ready_%0d", e), lsu_ready, (e % 4 == 3) ? 0 : 1);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    chk("t3_idle", idle, 1);

    // Random traffic against a scoreboard.
    stall = 0;
    for (int c = 0; c < 400; c++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
      lsu_valid = $urandom_range(0, 3) != 0;
      lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
      acc_l = lsu_valid && lsu_ready;
      acc_a = alu_valid && alu_ready;
      l_rd = lsu_rd; l_data = lsu_data; a_rd = alu_rd; a_data = alu_data;
      qn = q_rd.size();
      step();
      if (acc_l) begin
        chk("t6_lsu_we", reg_write, l_rd != 0);
        if (l_rd != 0) begin
          chk("t6_lsu_addr", rd_addr, l_rd);
          chk("t6_lsu_data", rd_data, l_data);
        end
        if (qn > 0) begin
          stall++;
          chk("t6_stall", stall <= 3, 1);
        end else stall = 0;
      end else if (qn > 0) begin
        chk("t6_alu_we", reg_write, 1);
        chk("t6_alu_addr", rd_addr, q_rd[0]);
        chk("t6_alu_data", rd_data, q_data[0]);
        void'(q_rd.pop_front());
        void'(q_data.pop_front());
        stall = 0;
      end else chk("t6_none_we", reg_write, 0);
      if (acc_a) begin
        q_rd.push_back(a_rd);
        q_data.push_back(a_data);
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      qn = q_rd.size();
      step();
      if (qn > 0) begin
        chk("t6_drain_addr", rd_addr, q_rd[0]);
        chk("t6_drain_data", rd_data, q_data[0]);
        chk("t6_drain_we", reg_write, 1);
        void'(q_rd.pop_front());
        void'(q_data.pop_front());
      end else chk("t6_drain_none", reg_write, 0);
    end
    chk("t6_queue_empty", q_rd.size(), 0);
    chk("t6_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
